// File: rtl/tx_arb_req_recorder.sv
// Arrival-order recorder for Tx-arbiter requests: one queue slot per pending source,
// exposes the two oldest entries and lets the arbiter retire either of them.

module tx_arb_req_recorder_cfg_chk #(
  parameter int NUM_SRC    = 5,
  parameter int FIFO_DEPTH = 8
) ();
  // One entry per source at most, so the queue can never overflow if it holds all sources.
  if (FIFO_DEPTH < NUM_SRC) begin : g_depth_too_small
    $error("tx_arb_req_recorder: FIFO_DEPTH (%0d) < NUM_SRC (%0d)", FIFO_DEPTH, NUM_SRC);
  end
endmodule

module tx_arb_req_recorder #(
  parameter int SRC_WIDTH  = 3,
  parameter int NUM_SRC    = 5,
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [1:0]           pop_sel_i,
  output logic [SRC_WIDTH-1:0] head_src_o,
  output logic [SRC_WIDTH-1:0] next_src_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 empty_o,
  output logic                 pop_err_o
);

  tx_arb_req_recorder_cfg_chk #(
    .NUM_SRC    (NUM_SRC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_cfg_chk ();

  logic [SRC_WIDTH-1:0] entry_q [FIFO_DEPTH];
  logic [SRC_WIDTH-1:0] entry_d [FIFO_DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic                 empty_q, empty_d;
  logic                 pop_err_q, pop_err_d;

  logic [NUM_SRC-1:0]   new_s;
  logic [NUM_SRC-1:0]   clr_s;
  logic                 pop_head_s, pop_second_s;
  logic [SRC_WIDTH-1:0] popped_src_s;
  logic [CNT_W-1:0]     cnt_pop_s, new_cnt_s;

  // Next-state: validate the pop, apply it, then append fresh requests in code order.
  always_comb begin
    int slot;
    pop_head_s   = 1'b0;
    pop_second_s = 1'b0;
    pop_err_d    = 1'b0;
    popped_src_s = {SRC_WIDTH{1'b0}};
    cnt_pop_s    = count_q;
    new_cnt_s    = {CNT_W{1'b0}};
    clr_s        = {NUM_SRC{1'b0}};
    slot         = 0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      entry_d[k] = entry_q[k];
    end

    case (pop_sel_i)
      2'b00: begin
        pop_err_d = 1'b0;
      end
      2'b01: begin
        if (count_q != {CNT_W{1'b0}}) pop_head_s = 1'b1;
        else                          pop_err_d  = 1'b1;
      end
      2'b10: begin
        if (count_q >= CNT_W'(2)) pop_second_s = 1'b1;
        else                      pop_err_d    = 1'b1;
      end
      default: begin
        pop_err_d = 1'b1;
      end
    endcase

    if (pop_head_s) begin
      popped_src_s = entry_q[0];
      for (int k = 0; k < FIFO_DEPTH - 1; k++) begin
        entry_d[k] = entry_q[k+1];
      end
      entry_d[FIFO_DEPTH-1] = {SRC_WIDTH{1'b0}};
      cnt_pop_s = count_q - CNT_W'(1);
    end else if (pop_second_s) begin
      popped_src_s = entry_q[1];
      for (int k = 1; k < FIFO_DEPTH - 1; k++) begin
        entry_d[k] = entry_q[k+1];
      end
      entry_d[FIFO_DEPTH-1] = {SRC_WIDTH{1'b0}};
      cnt_pop_s = count_q - CNT_W'(1);
    end else begin
      popped_src_s = {SRC_WIDTH{1'b0}};
    end

    // Codes start at 1, so a zero popped code never matches any source.
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_s[i] = (popped_src_s == SRC_WIDTH'(i + 1));
    end

    new_s = req_i & ~pending_q;
    slot  = int'(cnt_pop_s);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (new_s[i]) begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          if (k == slot) entry_d[k] = SRC_WIDTH'(i + 1);
          else           entry_d[k] = entry_d[k];
        end
        slot      = slot + 1;
        new_cnt_s = new_cnt_s + CNT_W'(1);
      end else begin
        slot = slot;
      end
    end

    pending_d = (pending_q & ~clr_s) | new_s;
    count_d   = cnt_pop_s + new_cnt_s;
    empty_d   = (count_d == {CNT_W{1'b0}});
  end

  // State registers; async reset drops every queued request.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        entry_q[k] <= {SRC_WIDTH{1'b0}};
      end
      count_q   <= {CNT_W{1'b0}};
      pending_q <= {NUM_SRC{1'b0}};
      empty_q   <= 1'b1;
      pop_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        entry_q[k] <= entry_d[k];
      end
      count_q   <= count_d;
      pending_q <= pending_d;
      empty_q   <= empty_d;
      pop_err_q <= pop_err_d;
    end
  end

  assign head_src_o = entry_q[0];
  assign next_src_o = entry_q[1];
  assign count_o    = count_q;
  assign empty_o    = empty_q;
  assign pop_err_o  = pop_err_q;

endmodule

// File: tb/tb_tx_arb_req_recorder.sv
// Directed bench for tx_arb_req_recorder: hand-computed queue contents after each edge.

module tb_tx_arb_req_recorder;

  logic       clk;
  logic       arst;
  logic [4:0] req_i;
  logic [1:0] pop_sel_i;
  logic [2:0] head_src_o;
  logic [2:0] next_src_o;
  logic [3:0] count_o;
  logic       empty_o;
  logic       pop_err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  tx_arb_req_recorder #(
    .SRC_WIDTH  (3),
    .NUM_SRC    (5),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .req_i      (req_i),
    .pop_sel_i  (pop_sel_i),
    .head_src_o (head_src_o),
    .next_src_o (next_src_o),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .pop_err_o  (pop_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input int head, input int nxt, input int cnt, input int err);
    check_val({tag, ".head"},  32'(head_src_o), 32'(head));
    check_val({tag, ".next"},  32'(next_src_o), 32'(nxt));
    check_val({tag, ".count"}, 32'(count_o),    32'(cnt));
    check_val({tag, ".empty"}, 32'(empty_o),    32'(cnt == 0));
    check_val({tag, ".err"},   32'(pop_err_o),  32'(err));
  endtask

  initial begin
    arst      = 1'b1;
    req_i     = 5'b11111;
    pop_sel_i = 2'b00;
    #1;
    check_q("rst0", 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_q("rst", 0, 0, 0, 0);
    end
    req_i = 5'b00000;
    arst  = 1'b0;
    tick();
    check_q("idle", 0, 0, 0, 0);

    // Arrival order: A2P_2 first, then MASTER while A2P_2 is still held.
    req_i = 5'b00010;
    tick();
    check_q("order1", 2, 0, 1, 0);
    req_i = 5'b00110;
    tick();
    check_q("order2", 2, 3, 2, 0);
    tick();
    check_q("order_nodup", 2, 3, 2, 0);
    req_i = 5'b00000; pop_sel_i = 2'b01;
    tick();
    check_q("order_pop1", 3, 0, 1, 0);
    tick();
    check_q("order_pop2", 0, 0, 0, 0);
    pop_sel_i = 2'b00;

    // Simultaneous arrivals land in ascending code order.
    req_i = 5'b10101;
    tick();
    check_q("simul", 1, 3, 3, 0);
    req_i = 5'b00000; pop_sel_i = 2'b01;
    tick();
    check_q("simul_pop", 3, 5, 2, 0);
    pop_sel_i = 2'b10;
    tick();
    check_q("simul_byp", 3, 0, 1, 0);
    pop_sel_i = 2'b01;
    tick();
    check_q("simul_drain", 0, 0, 0, 0);
    pop_sel_i = 2'b00;

    // Bypass with a same-cycle push: 2,1 -> retire second, MASTER joins -> 2,3.
    req_i = 5'b00010;
    tick();
    req_i = 5'b00011;
    tick();
    check_q("byp_setup", 2, 1, 2, 0);
    req_i = 5'b00110; pop_sel_i = 2'b10;
    tick();
    check_q("byp_push", 2, 3, 2, 0);
    req_i = 5'b00000; pop_sel_i = 2'b01;
    tick();
    tick();
    check_q("byp_drain", 0, 0, 0, 0);
    pop_sel_i = 2'b00;

    // Held request re-enqueues the cycle after it is retired, never duplicates.
    req_i = 5'b00001;
    tick();
    check_q("hold1", 1, 0, 1, 0);
    pop_sel_i = 2'b01;
    tick();
    check_q("hold_pop", 0, 0, 0, 0);
    pop_sel_i = 2'b00;
    tick();
    check_q("hold_reenq", 1, 0, 1, 0);
    tick();
    check_q("hold_nodup", 1, 0, 1, 0);
    req_i = 5'b00000; pop_sel_i = 2'b01;
    tick();
    check_q("hold_drain", 0, 0, 0, 0);

    // Illegal pops: flag for one cycle, queue untouched, pushes still honoured.
    pop_sel_i = 2'b01;
    tick();
    check_q("err_empty", 0, 0, 0, 1);
    pop_sel_i = 2'b00;
    tick();
    check_q("err_clr", 0, 0, 0, 0);
    req_i = 5'b00100;
    tick();
    req_i = 5'b00000; pop_sel_i = 2'b11;
    tick();
    check_q("err_11", 3, 0, 1, 1);
    pop_sel_i = 2'b10;
    tick();
    check_q("err_10", 3, 0, 1, 1);
    pop_sel_i = 2'b11; req_i = 5'b10000;
    tick();
    check_q("err_push", 3, 5, 2, 1);
    pop_sel_i = 2'b00; req_i = 5'b00000;
    tick();
    check_q("err_pulse", 3, 5, 2, 0);

    // Mid-operation reset drops the queue; a still-high request re-enters first edge.
    req_i = 5'b00010;
    arst  = 1'b1;
    #1;
    check_q("mid_rst", 0, 0, 0, 0);
    tick();
    check_q("mid_rst_hold", 0, 0, 0, 0);
    arst = 1'b0;
    tick();
    check_q("post_rst", 2, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
